// File: rtl/reg_bank_arb_pkg.sv
// Shared sizes and lock-state encoding for the register-bank arbiter.
// The lock state is only used when REG_BANK_ARB_LOCK_EN is defined.
package reg_bank_arb_pkg;

    localparam int N_REQ    = 4;
    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 2;
    localparam int LOCK_MAX = 8;
    localparam int ID_W     = 2;
    localparam int CNT_W    = 3;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search starting at ptr, and the pointer register.
// The parent decides when ptr moves and which index it moves past.
module rr_arbiter
    import reg_bank_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             upd,
    input  logic [ID_W-1:0]  upd_idx,
    output logic             any,
    output logic [ID_W-1:0]  win_idx
);

    logic [ID_W-1:0] ptr;

    always_comb begin
        logic [ID_W-1:0] cand;
        any     = 1'b0;
        win_idx = ptr;
        cand    = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + ID_W'(k);
            if (!any && req[cand]) begin
                any     = 1'b1;
                win_idx = cand;
            end
        end
    end

    // The 2-bit add wraps naturally, giving (upd_idx + 1) mod 4.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= upd_idx + ID_W'(1);
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Four requesters write a 4x4-bit register bank through a round-robin grant.
// Optional grant holding is compiled in with REG_BANK_ARB_LOCK_EN.
module reg_bank_arbiter
    import reg_bank_arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   wr_addr,
    input  logic [N_REQ*DATA_W-1:0]   wr_data,
`ifdef REG_BANK_ARB_LOCK_EN
    input  logic [N_REQ-1:0]          lock,
`endif
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ*DATA_W-1:0]   reg_q,
    output logic                      wr_valid,
    output logic [ID_W-1:0]           last_id
);

    logic              any;
    logic [ID_W-1:0]   win_idx;
    logic              upd;
    logic [ID_W-1:0]   upd_idx;
    logic              grant;
    logic [ID_W-1:0]   gnt_idx;
    logic [ADDR_W-1:0] wr_sel;
    logic [DATA_W-1:0] wr_val;
    logic [DATA_W-1:0] bank [N_REQ];

    rr_arbiter u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .upd     (upd),
        .upd_idx (upd_idx),
        .any     (any),
        .win_idx (win_idx)
    );

`ifdef REG_BANK_ARB_LOCK_EN
    lock_state_t      state;
    logic [ID_W-1:0]  owner;
    logic [CNT_W-1:0] cnt;
    logic             lock_exit;

    // The edge that would bring cnt to LOCK_MAX-1 is the last locked edge.
    assign lock_exit = !lock[owner] || (cnt == CNT_W'(LOCK_MAX - 2));

    always_comb begin
        grant   = any;
        gnt_idx = win_idx;
        upd     = any;
        upd_idx = win_idx;
        if (state == LOCKED) begin
            grant   = req[owner];
            gnt_idx = owner;
            upd     = lock_exit;
            upd_idx = owner;
        end else if (any && lock[win_idx]) begin
            upd = 1'b0;
        end
        gnt = grant ? (N_REQ'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= UNLOCKED;
            owner <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (any && lock[win_idx]) begin
                        state <= LOCKED;
                        owner <= win_idx;
                        cnt   <= '0;
                    end
                end
                LOCKED: begin
                    if (lock_exit) begin
                        state <= UNLOCKED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= UNLOCKED;
            endcase
        end
    end
`else
    always_comb begin
        grant   = any;
        gnt_idx = win_idx;
        upd     = any;
        upd_idx = win_idx;
        gnt     = grant ? (N_REQ'(1) << gnt_idx) : '0;
    end
`endif

    assign wr_sel = wr_addr[ADDR_W*gnt_idx +: ADDR_W];
    assign wr_val = wr_data[DATA_W*gnt_idx +: DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_REQ; k++) begin
                bank[k] <= '0;
            end
            wr_valid <= 1'b0;
            last_id  <= '0;
        end else begin
            wr_valid <= grant;
            if (grant) begin
                bank[wr_sel] <= wr_val;
                last_id      <= gnt_idx;
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int k = 0; k < N_REQ; k++) begin
            reg_q[DATA_W*k +: DATA_W] = bank[k];
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: reference round-robin model, expected-bank queue,
// directed cases for idle, single write, rotation, same-entry, reset and lock.
module tb_reg_bank_arbiter;
    import reg_bank_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  lock = '0;
    logic [3:0]  gnt;
    logic [15:0] reg_q;
    logic        wr_valid;
    logic [1:0]  last_id;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [1:0]  m_ptr = '0;
    logic [15:0] m_reg = '0;
    logic [1:0]  m_last = '0;
    logic [3:0]  seen_gnt = '0;
    logic [3:0]  rot_tbl [8];

    reg_bank_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
`ifdef REG_BANK_ARB_LOCK_EN
        .lock     (lock),
`endif
        .gnt      (gnt),
        .reg_q    (reg_q),
        .wr_valid (wr_valid),
        .last_id  (last_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_gnt(input logic [3:0] r, input logic [1:0] p);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = (int'(p) + k) % 4;
            if (r[i]) return 4'b0001 << i;
        end
        return 4'b0000;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        lock = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ptr = '0;
        m_reg = '0;
        m_last = '0;
        exp_q.delete();
        check("rst_reg_q", reg_q, 16'h0000);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_last_id", last_id, 2'd0);
    endtask

    // Inputs are already driven; compare gnt mid-cycle, then the bank after the edge.
    task automatic tick();
        logic [3:0] eg;
        int i;
        logic [1:0] a;
        logic [3:0] d;
        @(negedge clk);
        eg = model_gnt(req, m_ptr);
        seen_gnt = gnt;
        check("gnt", gnt, eg);
        i = 0;
        for (int k = 0; k < 4; k++) if (eg[k]) i = k;
        if (eg != 0) begin
            a = wr_addr[2*i +: 2];
            d = wr_data[4*i +: 4];
            m_reg[4*a +: 4] = d;
            exp_q.push_back(m_reg);
            m_ptr = 2'(i + 1);
            m_last = 2'(i);
        end
        @(posedge clk);
        #1;
        check("wr_valid", wr_valid, eg != 0);
        if (eg != 0) begin
            if (exp_q.size() == 0) begin
                check("exp_q_empty", 1, 0);
            end else begin
                check("reg_q", reg_q, exp_q.pop_front());
            end
        end else begin
            check("reg_q_hold", reg_q, m_reg);
        end
        check("last_id", last_id, m_last);
    endtask

    initial begin
        rot_tbl[0] = 4'b0001; rot_tbl[1] = 4'b0010; rot_tbl[2] = 4'b0100; rot_tbl[3] = 4'b1000;
        rot_tbl[4] = 4'b0001; rot_tbl[5] = 4'b0010; rot_tbl[6] = 4'b0100; rot_tbl[7] = 4'b1000;

        do_reset();

        // Idle after reset.
        for (int c = 0; c < 5; c++) begin
            req = '0;
            wr_addr = 8'($urandom);
            wr_data = 16'($urandom);
            tick();
            check("idle_gnt", seen_gnt, 4'b0000);
            check("idle_reg_q", reg_q, 16'h0000);
        end

        // Single write from requester 2 to entry 3.
        req = 4'b0100;
        wr_addr = 8'b0011_0000;
        wr_data = 16'h0A00;
        tick();
        check("single_gnt", seen_gnt, 4'b0100);
        check("single_entry3", reg_q[15:12], 4'hA);
        check("single_wr_valid", wr_valid, 1'b1);
        check("single_last_id", last_id, 2'd2);
        req = '0;
        tick();

        // Full-load rotation from ptr=0.
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            wr_addr = 8'($urandom);
            wr_data = 16'($urandom);
            tick();
            check("rot_gnt", seen_gnt, rot_tbl[c]);
        end
        req = '0;

        // Two writers to entry 1: data 5 from req0, then 9 from req1.
        do_reset();
        req = 4'b0011;
        wr_addr = 8'b0000_0101;
        wr_data = 16'h0095;
        tick();
        check("same_first", reg_q[7:4], 4'h5);
        req = 4'b0010;
        tick();
        check("same_second", reg_q[7:4], 4'h9);
        req = '0;

        // Random traffic including idle cycles.
        for (int c = 0; c < 60; c++) begin
            req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) req = '0;
            wr_addr = 8'($urandom);
            wr_data = 16'($urandom);
            tick();
        end
        req = '0;

        // Reset coinciding with a grant must not write.
        req = 4'b0001;
        wr_addr = 8'h00;
        wr_data = 16'h0003;
        tick();
        check("pre_rst_entry0", reg_q[3:0], 4'h3);
        reset = 1'b1;
        req = 4'b0001;
        wr_data = 16'h000F;
        @(posedge clk);
        #1;
        check("rst_wr_entry0", reg_q[3:0], 4'h0);
        check("rst_wr_reg_q", reg_q, 16'h0000);
        check("rst_wr_valid_lo", wr_valid, 1'b0);
        reset = 1'b0;
        req = '0;
        m_ptr = '0;
        m_reg = '0;
        m_last = '0;
        exp_q.delete();
        tick();

`ifdef REG_BANK_ARB_LOCK_EN
        // Held lock: eight cycles to requester 0, then requester 1.
        do_reset();
        req = 4'b0011;
        lock = 4'b0001;
        wr_addr = 8'b0000_0100;
        wr_data = 16'h0021;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check("lock_gnt", gnt, (c < 8) ? 4'b0001 : 4'b0010);
            @(posedge clk);
            #1;
            check("lock_wr_valid", wr_valid, 1'b1);
        end
        check("lock_entry1", reg_q[7:4], 4'h2);
        check("lock_entry0", reg_q[3:0], 4'h1);
        // Reset while locked leaves no owner behind.
        @(negedge clk);
        check("relock_gnt", gnt, 4'b0001);
        do_reset();
        req = 4'b0010;
        lock = '0;
        tick();
        check("post_lock_rst_gnt", seen_gnt, 4'b0010);
        req = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
